run_monitor: RTL and testbench

Synthesizable run-control and cycle-accounting block for the processor core. It replaces the simulation-only halt/timeout logic with a parametrised unit with these features:
- explicit start/clear control
- configurable watchdog limit
- post-halt drain window, so in-flight pipeline writes complete before done
- N saturating event counters, e.g. retired instructions and stall cycles

It sits beside the core. Testbenches and debug logic read its outputs.

---
 rtl/run_pkg.sv | 24 ++
 rtl/sat_counter.sv | 37 +++
 rtl/run_monitor.sv | 140 ++++++++++++++
 tb/tb_run_monitor.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/run_pkg.sv
// ============================================================================
// Module      : run_pkg
// Description : Shared state encoding and default constants for run_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package run_pkg;

    localparam int CYC_W_DEF      = 16;
    localparam int MAX_CYCLES_DEF = 10000;
    localparam int DRAIN_DEF      = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        DRAIN   = 3'd2,
        DONE    = 3'd3,
        TIMEOUT = 3'd4
    } run_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones, with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] C_ONE = W'(1);
    localparam logic [W-1:0] C_MAX = {W{1'b1}};

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != C_MAX)) begin
            r_count <= r_count + C_ONE;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/run_monitor.sv
// ============================================================================
// Module      : run_monitor
// Description : Run control, watchdog, post-halt drain and event accounting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module run_monitor
    import run_pkg::*;
#(
    parameter int CYC_W        = CYC_W_DEF,
    parameter int MAX_CYCLES   = MAX_CYCLES_DEF,
    parameter int DRAIN_CYCLES = DRAIN_DEF,
    parameter int NUM_EVT      = 2,
    parameter int EVT_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     halt,
    input  logic                     clear,
    input  logic [NUM_EVT-1:0]       evt,
    output logic                     running,
    output logic                     done,
    output logic                     timed_out,
    output logic [CYC_W-1:0]         cycles,
    output logic [CYC_W-1:0]         halt_cycle,
    output logic [NUM_EVT*EVT_W-1:0] evt_count
);

    localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [CYC_W-1:0] C_CYC_ONE   = CYC_W'(1);
    localparam logic [CYC_W-1:0] C_CYC_LIMIT = CYC_W'(MAX_CYCLES);
    localparam logic [DW-1:0]    C_DRN_ONE   = DW'(1);
    localparam logic [DW-1:0]    C_DRN_INIT  = DW'(DRAIN_CYCLES);

    run_state_t       r_state;
    logic [CYC_W-1:0] r_cycles;
    logic [CYC_W-1:0] r_halt_cycle;
    logic [DW-1:0]    r_drain_cnt;
    logic             r_running;
    logic             r_done;
    logic             r_timed_out;

    logic w_cnt_en;
    logic w_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cycles     <= '0;
            r_halt_cycle <= '0;
            r_drain_cnt  <= '0;
            r_running    <= 1'b0;
            r_done       <= 1'b0;
            r_timed_out  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                RUN: begin
                    // Halt is checked first so it wins over the watchdog.
                    if (halt) begin
                        r_halt_cycle <= r_cycles;
                        r_cycles     <= r_cycles + C_CYC_ONE;
                        if (DRAIN_CYCLES == 0) begin
                            r_state   <= DONE;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_state     <= DRAIN;
                            r_drain_cnt <= C_DRN_INIT;
                        end
                    end else if (r_cycles == C_CYC_LIMIT) begin
                        r_state     <= TIMEOUT;
                        r_running   <= 1'b0;
                        r_timed_out <= 1'b1;
                    end else begin
                        r_cycles <= r_cycles + C_CYC_ONE;
                    end
                end
                DRAIN: begin
                    r_cycles <= r_cycles + C_CYC_ONE;
                    if (r_drain_cnt == C_DRN_ONE) begin
                        r_state   <= DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - C_DRN_ONE;
                    end
                end
                DONE, TIMEOUT: begin
                    if (clear) begin
                        r_state      <= IDLE;
                        r_cycles     <= '0;
                        r_halt_cycle <= '0;
                        r_drain_cnt  <= '0;
                        r_done       <= 1'b0;
                        r_timed_out  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_running   <= 1'b0;
                    r_done      <= 1'b0;
                    r_timed_out <= 1'b0;
                end
            endcase
        end
    end

    assign w_cnt_en = (r_state == RUN) || (r_state == DRAIN);
    assign w_clr    = ((r_state == DONE) || (r_state == TIMEOUT)) && clear;

    for (genvar gi = 0; gi < NUM_EVT; gi++) begin : g_evt
        sat_counter #(
            .W(EVT_W)
        ) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .clr  (w_clr),
            .inc  (w_cnt_en & evt[gi]),
            .count(evt_count[gi*EVT_W +: EVT_W])
        );
    end

    assign running    = r_running;
    assign done       = r_done;
    assign timed_out  = r_timed_out;
    assign cycles     = r_cycles;
    assign halt_cycle = r_halt_cycle;

endmodule

`default_nettype wire

// File: tb/tb_run_monitor.sv
// ============================================================================
// Module      : tb_run_monitor
// Description : Randomised scoreboard bench for run_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_run_monitor;

    localparam int MAXC = 20;
    localparam int DRN  = 2;
    localparam int SAT  = 15;

    typedef struct {
        bit is_done;
        int cyc;
        int hcyc;
        int e0;
        int e1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        halt;
    logic        clear;
    logic [1:0]  evt;
    logic        running;
    logic        done;
    logic        timed_out;
    logic [15:0] cycles;
    logic [15:0] halt_cycle;
    logic [7:0]  evt_count;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t q[$];

    run_monitor #(
        .CYC_W       (16),
        .MAX_CYCLES  (MAXC),
        .DRAIN_CYCLES(DRN),
        .NUM_EVT     (2),
        .EVT_W       (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .halt      (halt),
        .clear     (clear),
        .evt       (evt),
        .running   (running),
        .done      (done),
        .timed_out (timed_out),
        .cycles    (cycles),
        .halt_cycle(halt_cycle),
        .evt_count (evt_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic int sat(int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: on each new done/timeout, compare against the oldest expectation.
    bit seen = 1'b0;
    always @(negedge clk) begin
        if (rst_n && (done || timed_out) && !seen) begin
            seen = 1'b1;
            if (q.size() == 0) begin
                chk("sb_unexpected_end", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("end_done",       int'(done),            e.is_done ? 1 : 0);
                chk("end_timed_out",  int'(timed_out),       e.is_done ? 0 : 1);
                chk("end_running",    int'(running),         0);
                chk("end_cycles",     int'(cycles),          e.cyc);
                chk("end_halt_cycle", int'(halt_cycle),      e.hcyc);
                chk("end_evt0",       int'(evt_count[3:0]),  e.e0);
                chk("end_evt1",       int'(evt_count[7:4]),  e.e1);
            end
        end
        if (!done && !timed_out) seen = 1'b0;
    end

    // h < 0 means the run is left to time out; dens is evt probability in percent.
    task automatic do_run(int h, int dens);
        int   s0;
        int   s1;
        int   c;
        exp_t e;
        s0 = 0;
        s1 = 0;
        c  = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("run_started", int'(running), 1);
        while (1) begin
            evt[0] = ($urandom_range(99) < dens);
            evt[1] = ($urandom_range(99) < dens);
            s0 += int'(evt[0]);
            s1 += int'(evt[1]);
            if (c == h) begin
                halt = 1'b1;
                break;
            end
            if (c == MAXC) break;
            step();
            c++;
        end
        if (h >= 0) begin
            step();
            halt = 1'b0;
            chk("drain_running", int'(running), 1);
            for (int d = 0; d < DRN; d++) begin
                evt[0] = ($urandom_range(99) < dens);
                evt[1] = ($urandom_range(99) < dens);
                s0 += int'(evt[0]);
                s1 += int'(evt[1]);
                halt = 1'($urandom_range(1));
                if (d == DRN - 1) begin
                    e = '{1'b1, h + 1 + DRN, h, sat(s0), sat(s1)};
                    q.push_back(e);
                end
                step();
                if (d < DRN - 1) chk("drain_running", int'(running), 1);
            end
        end else begin
            e = '{1'b0, MAXC, 0, sat(s0), sat(s1)};
            q.push_back(e);
            step();
        end
        halt = 1'b0;
        chk("end_not_running", int'(running), 0);
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            evt = 2'($urandom_range(3));
            step();
        end
        start = 1'b0;
        evt   = 2'b00;
        chk("frozen_cycles", int'(cycles), e.cyc);
        chk("frozen_evt", int'(evt_count), (e.e1 << 4) | e.e0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_cycles", int'(cycles), 0);
        chk("clr_halt_cycle", int'(halt_cycle), 0);
        chk("clr_evt", int'(evt_count), 0);
        chk("clr_flags", int'({done, timed_out, running}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation timeout");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        halt  = 1'b0;
        clear = 1'b0;
        evt   = 2'b00;
        repeat (2) step();
        chk("rst_flags", int'({running, done, timed_out}), 0);
        chk("rst_cycles", int'(cycles), 0);
        chk("rst_halt_cycle", int'(halt_cycle), 0);
        chk("rst_evt", int'(evt_count), 0);
        rst_n = 1'b1;

        // IDLE must ignore halt, evt and clear.
        halt  = 1'b1;
        evt   = 2'b11;
        clear = 1'b1;
        repeat (3) step();
        chk("idle_running", int'(running), 0);
        chk("idle_cycles", int'(cycles), 0);
        chk("idle_evt", int'(evt_count), 0);
        halt  = 1'b0;
        evt   = 2'b00;
        clear = 1'b0;

        do_run(5, 50);
        do_run(-1, 50);
        do_run(MAXC, 100);
        do_run(0, 0);
        do_run(MAXC - 1, 10);
        for (int r = 0; r < 25; r++) begin
            int h;
            h = ($urandom_range(3) == 0) ? -1 : int'($urandom_range(MAXC));
            do_run(h, int'($urandom_range(100)));
        end

        // Asynchronous reset while draining.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) begin
            evt = 2'b11;
            step();
        end
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("pre_rst_drain", int'(running), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_flags", int'({running, done, timed_out}), 0);
        chk("async_rst_cycles", int'(cycles), 0);
        chk("async_rst_halt_cycle", int'(halt_cycle), 0);
        chk("async_rst_evt", int'(evt_count), 0);
        step();
        rst_n = 1'b1;
        evt   = 2'b00;
        halt  = 1'b1;
        repeat (3) step();
        chk("post_rst_idle", int'(running), 0);
        chk("post_rst_cycles", int'(cycles), 0);
        halt = 1'b0;
        do_run(7, 30);

        chk("sb_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
